// File: rtl/la_bridge_pkg.sv
// Shared constants for the logic-analyser stream bridge: status bit positions,
// default parameter values and the occupancy-width helper.
package la_bridge_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 8;
  localparam int CH_W_DEF   = 2;

  localparam int ST_ACK   = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_FULL  = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_PERR  = 4;
  localparam int ST_OCC   = 5;

  // Occupancy must represent 0..DEPTH inclusive, hence one bit more than the pointer.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/la_stream_bridge_if.sv
// Stream side of the bridge: valid/ready word transfer with a channel tag.
// A word moves on a clock edge where valid and ready are both high; the producer
// holds valid, data and ch stable until that edge, and ready may change freely.
interface la_stream_bridge_if
  import la_bridge_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CH_W   = CH_W_DEF
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CH_W-1:0]   ch;

  modport master (output valid, data, ch, input ready);
  modport slave  (input valid, data, ch, output ready);
endinterface

// File: rtl/la_bridge_sync.sv
// Two-flop synchroniser for a single level signal, async active-low reset to 0.
module la_bridge_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);
  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/la_stream_bridge.sv
// Host-toggle write port into a tagged FIFO drained as a valid/ready stream.
// Optional parity checking of host words is compiled in with LA_BRIDGE_PARITY_EN.
module la_stream_bridge
  import la_bridge_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int CH_W   = CH_W_DEF
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_n_i,
  input  logic [DATA_W-1:0]           la_data_i,
  input  logic [CH_W-1:0]             la_ch_i,
  input  logic                        la_par_i,
  input  logic [1:0]                  la_ctrl_i,
  output logic                        m_valid_o,
  input  logic                        m_ready_i,
  output logic [DATA_W-1:0]           m_data_o,
  output logic [CH_W-1:0]             m_ch_o,
  output logic [5+cnt_w(DEPTH)-1:0]   la_status_o
);
  localparam int CW = cnt_w(DEPTH);
  localparam int AW = $clog2(DEPTH);
  localparam int W  = CH_W + DATA_W;

  logic wr_tog_s, flush_s;

  la_bridge_sync u_sync_wr (
    .clk_i (wb_clk_i), .rst_ni (wb_rst_n_i), .d_i (la_ctrl_i[0]), .q_o (wr_tog_s)
  );
  la_bridge_sync u_sync_flush (
    .clk_i (wb_clk_i), .rst_ni (wb_rst_n_i), .d_i (la_ctrl_i[1]), .q_o (flush_s)
  );

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hist_q, hist_d;
  logic          ack_q, ack_d;
  logic          ovf_q, ovf_d;
  logic          perr_q, perr_d;

  logic wr_evt, par_ok, full, empty, pop, push;

`ifdef LA_BRIDGE_PARITY_EN
  // Even parity: the XOR of tag, data and parity bit must be zero.
  assign par_ok = ~^{la_ch_i, la_data_i, la_par_i};
`else
  logic unused_par;
  assign unused_par = la_par_i;
  assign par_ok     = 1'b1;
`endif

  assign wr_evt = wr_tog_s ^ hist_q;
  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == CW'(DEPTH));
  assign pop    = !empty && m_ready_i;

  always_comb begin
    hist_d   = wr_tog_s;
    ack_d    = ack_q;
    ovf_d    = ovf_q;
    perr_d   = perr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    mem_d    = mem_q;
    push     = 1'b0;

    if (wr_evt) ack_d = ~ack_q;

    if (flush_s) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
      perr_d   = 1'b0;
    end else begin
      // A full FIFO still accepts a word when the head leaves on the same edge.
      push = wr_evt && par_ok && (!full || pop);
      if (wr_evt && !par_ok) perr_d = 1'b1;
      if (wr_evt && par_ok && full && !pop) ovf_d = 1'b1;
      if (push) begin
        mem_d[wr_ptr_q] = {la_ch_i, la_data_i};
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      hist_q   <= 1'b0;
      ack_q    <= 1'b0;
      ovf_q    <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      hist_q   <= hist_d;
      ack_q    <= ack_d;
      ovf_q    <= ovf_d;
      perr_q   <= perr_d;
    end
  end

  assign m_valid_o = !empty;
  assign m_data_o  = mem_q[rd_ptr_q][DATA_W-1:0];
  assign m_ch_o    = mem_q[rd_ptr_q][W-1:DATA_W];

  always_comb begin
    la_status_o             = '0;
    la_status_o[ST_ACK]     = ack_q;
    la_status_o[ST_EMPTY]   = empty;
    la_status_o[ST_FULL]    = full;
    la_status_o[ST_OVF]     = ovf_q;
    la_status_o[ST_PERR]    = perr_q;
    la_status_o[ST_OCC+:CW] = cnt_q;
  end
endmodule

// File: tb/tb_la_stream_bridge.sv
// Self-checking bench for la_stream_bridge: table-driven fill/overflow vectors,
// hand-written sequences for pop-on-push, flush, parity and async reset.
module tb_la_stream_bridge;
  import la_bridge_pkg::*;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int CH_W   = 2;
  localparam int CW     = cnt_w(DEPTH);
  localparam int SW     = 5 + CW;
  localparam int W      = CH_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] la_data = '0;
  logic [CH_W-1:0]   la_ch = '0;
  logic              la_par = 1'b0;
  logic [1:0]        la_ctrl = '0;
  logic [SW-1:0]     status;

  always #5 clk = ~clk;

  la_stream_bridge_if #(.DATA_W(DATA_W), .CH_W(CH_W)) strm ();

  la_stream_bridge #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CH_W(CH_W)) dut (
    .wb_clk_i    (clk),
    .wb_rst_n_i  (rst_n),
    .la_data_i   (la_data),
    .la_ch_i     (la_ch),
    .la_par_i    (la_par),
    .la_ctrl_i   (la_ctrl),
    .m_valid_o   (strm.valid),
    .m_ready_i   (strm.ready),
    .m_data_o    (strm.data),
    .m_ch_o      (strm.ch),
    .la_status_o (status)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic        exp_ack = 1'b0;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [CH_W-1:0]   ch;
    int                exp_occ;
    logic              exp_ovf;
    logic              push;
  } vec_t;
  vec_t tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic good_par(input logic [DATA_W-1:0] d, input logic [CH_W-1:0] c);
    return ^{c, d};
  endfunction

  function automatic logic [SW-1:0] exp_status(input int occ, input logic ovf, input logic perr);
    logic [SW-1:0] s;
    s             = '0;
    s[ST_ACK]     = exp_ack;
    s[ST_EMPTY]   = (occ == 0);
    s[ST_FULL]    = (occ == DEPTH);
    s[ST_OVF]     = ovf;
    s[ST_PERR]    = perr;
    s[ST_OCC+:CW] = CW'(occ);
    return s;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_start(input logic [DATA_W-1:0] d, input logic [CH_W-1:0] c,
                             input logic p, input logic expect_push);
    la_data    = d;
    la_ch      = c;
    la_par     = p;
    la_ctrl[0] = ~la_ctrl[0];
    exp_ack    = ~exp_ack;
    if (expect_push) exp_q.push_back({c, d});
  endtask

  task automatic write(input logic [DATA_W-1:0] d, input logic [CH_W-1:0] c, input logic expect_push);
    write_start(d, c, good_par(d, c), expect_push);
    step(3);
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    la_ctrl    = '0;
    strm.ready = 1'b0;
    step(2);
    exp_q.delete();
    exp_ack = 1'b0;
    rst_n   = 1'b1;
    step(1);
  endtask

  task automatic drain(input string name);
    int cyc;
    strm.ready = 1'b1;
    cyc = 0;
    while (strm.valid && cyc < 4 * DEPTH) begin
      step(1);
      cyc++;
    end
    strm.ready = 1'b0;
    check({name, "_valid_low"}, 32'(strm.valid), 32'd0);
    check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Stream scoreboard: every transfer must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && strm.valid && strm.ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL stream_unexpected: actual 0x%0h required none", {strm.ch, strm.data});
      end else begin
        check("stream_word", 32'({strm.ch, strm.data}), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    logic [DATA_W-1:0] d;
    logic [CH_W-1:0]   c;
    strm.ready = 1'b0;

    // Reset state and first write latency
    do_reset();
    check("rst_valid", 32'(strm.valid), 32'd0);
    check("rst_data", 32'(strm.data), 32'd0);
    check("rst_ch", 32'(strm.ch), 32'd0);
    check("rst_status", 32'(status), 32'(exp_status(0, 1'b0, 1'b0)));
    write_start(16'h1234, 2'd2, good_par(16'h1234, 2'd2), 1'b1);
    step(2);
    check("first_valid_early", 32'(strm.valid), 32'd0);
    step(1);
    check("first_valid", 32'(strm.valid), 32'd1);
    check("first_data", 32'(strm.data), 32'h1234);
    check("first_ch", 32'(strm.ch), 32'd2);
    check("first_status", 32'(status), 32'(exp_status(1, 1'b0, 1'b0)));
    drain("first");

    // Full FIFO with a pop on the push edge
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      d = DATA_W'($urandom_range(0, 65535));
      c = CH_W'($urandom_range(0, 3));
      write(d, c, 1'b1);
    end
    check("fill_status", 32'(status), 32'(exp_status(DEPTH, 1'b0, 1'b0)));
    d = 16'hBEEF;
    c = 2'd1;
    write_start(d, c, good_par(d, c), 1'b1);
    step(2);
    strm.ready = 1'b1;
    step(1);
    strm.ready = 1'b0;
    check("poppush_status", 32'(status), 32'(exp_status(DEPTH, 1'b0, 1'b0)));
    drain("poppush");

    // Table-driven overflow: one write beyond capacity with the consumer stalled
    do_reset();
    for (int i = 0; i < 9; i++) begin
      tbl[i].data    = DATA_W'($urandom_range(0, 65535));
      tbl[i].ch      = CH_W'($urandom_range(0, 3));
      tbl[i].exp_occ = (i < DEPTH) ? i + 1 : DEPTH;
      tbl[i].exp_ovf = (i >= DEPTH);
      tbl[i].push    = (i < DEPTH);
    end
    for (int i = 0; i < 9; i++) begin
      write(tbl[i].data, tbl[i].ch, tbl[i].push);
      check($sformatf("ovf_status_%0d", i), 32'(status),
            32'(exp_status(tbl[i].exp_occ, tbl[i].exp_ovf, 1'b0)));
    end
    check("ovf_head_hold", 32'(strm.data), 32'(tbl[0].data));
    check("ovf_ack_flips", 32'(status[ST_ACK]), 32'd1);
    drain("ovf");
    check("ovf_sticky", 32'(status), 32'(exp_status(0, 1'b1, 1'b0)));

    // Flush with four words queued and a write arriving mid-flush
    for (int i = 0; i < 4; i++) write(DATA_W'(16'h0A00 + i), CH_W'(i), 1'b1);
    check("preflush_status", 32'(status), 32'(exp_status(4, 1'b1, 1'b0)));
    la_ctrl[1] = 1'b1;
    step(2);
    exp_q.delete();
    write_start(16'h5555, 2'd3, good_par(16'h5555, 2'd3), 1'b0);
    step(3);
    check("flush_valid", 32'(strm.valid), 32'd0);
    check("flush_status", 32'(status), 32'(exp_status(0, 1'b0, 1'b0)));
    la_ctrl[1] = 1'b0;
    step(3);
    check("postflush_status", 32'(status), 32'(exp_status(0, 1'b0, 1'b0)));

    // Parity mismatch on 0x0001 / ch 0 with parity bit 0
    do_reset();
`ifdef LA_BRIDGE_PARITY_EN
    write_start(16'h0001, 2'd0, 1'b0, 1'b0);
    step(3);
    check("par_status", 32'(status), 32'(exp_status(0, 1'b0, 1'b1)));
`else
    write_start(16'h0001, 2'd0, 1'b0, 1'b1);
    step(3);
    check("par_status", 32'(status), 32'(exp_status(1, 1'b0, 1'b0)));
`endif
    drain("par");

    // Asynchronous reset mid-stream with three words queued
    do_reset();
    for (int i = 0; i < 3; i++) write(DATA_W'(16'hC000 + 3 * i), CH_W'(i + 1), 1'b1);
    check("pre_arst_status", 32'(status), 32'(exp_status(3, 1'b0, 1'b0)));
    #3;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_ack = 1'b0;
    check("arst_valid", 32'(strm.valid), 32'd0);
    check("arst_data", 32'(strm.data), 32'd0);
    check("arst_ch", 32'(strm.ch), 32'd0);
    check("arst_status", 32'(status), 32'(exp_status(0, 1'b0, 1'b0)));
    la_ctrl = '0;
    step(2);
    rst_n = 1'b1;
    step(3);
    check("post_arst_status", 32'(status), 32'(exp_status(0, 1'b0, 1'b0)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/la_stream_bridge.md
LA_STREAM_BRIDGE -- requirements
Module: la_stream_bridge

Interface
REQ-001 SHALL have parameter DATA_W, default 16, host word width (4..32).
REQ-002 SHALL have parameter DEPTH, default 8, FIFO entries, power of two (2..64).
REQ-003 SHALL have parameter CH_W, default 2, channel-tag width (1..4).
REQ-004 SHALL have port wb_clk_i, input, 1, the single clock.
REQ-005 SHALL have port wb_rst_n_i, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port la_data_i, input, DATA_W, host data word; host holds it stable until ack.
REQ-007 SHALL have port la_ch_i, input, CH_W, channel tag for la_data_i.
REQ-008 SHALL have port la_par_i, input, 1, even parity over {la_ch_i, la_data_i}.
REQ-009 SHALL have port la_ctrl_i, input, 2: bit0 write toggle, bit1 flush level.
REQ-010 SHALL have port m_valid_o, output, 1, stream word valid.
REQ-011 SHALL have port m_ready_i, input, 1, stream consumer ready.
REQ-012 SHALL have port m_data_o, output, DATA_W, head-of-FIFO data.
REQ-013 SHALL have port m_ch_o, output, CH_W, head-of-FIFO tag.
REQ-014 SHALL have port la_status_o, output, 5+CW with CW=log2(DEPTH)+1: [0] ack toggle, [1] empty, [2] full, [3] overflow sticky, [4] parity-error sticky, [5+:CW] occupancy.

Function
REQ-015 SHALL pass la_ctrl_i[0] and la_ctrl_i[1] each through a 2-flop synchroniser, plus one history flop on bit0.
REQ-016 SHALL raise a write event when synchronised bit0 differs from its history flop; either toggle direction counts.
REQ-017 SHALL capture {la_ch_i, la_data_i} into the FIFO on the edge following the write event: 3 clock edges after the toggle change.
REQ-018 SHALL set m_valid_o on that same edge when the FIFO was empty; m_valid_o = !empty, driven from registers.
REQ-019 SHALL pop the head when m_valid_o && m_ready_i at a clock edge; m_data_o/m_ch_o present the new head on the next cycle.
REQ-020 SHALL hold m_data_o/m_ch_o stable while m_valid_o && !m_ready_i.
REQ-021 SHALL drop a write event while full, set overflow sticky, leave occupancy unchanged.
REQ-022 SHALL accept a push when full if a pop occurs on the same edge; occupancy stays DEPTH and overflow is not set.
REQ-023 SHALL flip the ack toggle (status[0]) on every processed write event: accepted, dropped, or parity-rejected.
REQ-024 SHALL wrap read/write pointers modulo DEPTH; occupancy saturates at 0 and DEPTH and never wraps.
REQ-025 SHALL, while synchronised flush is high, reset pointers and occupancy, clear both stickies, drop write events without setting overflow, and hold m_valid_o low; ack still toggles.

Reset
REQ-026 SHALL on wb_rst_n_i low asynchronously clear all flops: m_valid_o=0, m_data_o=0, m_ch_o=0, status = empty=1 only, all other status bits 0.
REQ-027 SHALL deassert reset synchronously to wb_clk_i externally; mid-operation reset discards FIFO contents and synchroniser state.

Configuration
REQ-028 SHALL compile parity checking in with macro LA_BRIDGE_PARITY_EN: an event with parity mismatch is not pushed and sets status[4].
REQ-029 SHALL, without LA_BRIDGE_PARITY_EN, ignore la_par_i and tie status[4] to 0; the port list is unchanged.

Structure
REQ-030 SHALL place status bit-index constants, default parameter values and the count-width function in package la_bridge_pkg.
REQ-031 SHALL implement the synchroniser as sub-module la_bridge_sync (2 flops, async active-low reset to 0), instantiated twice.

Verification
REQ-032 Reset, then toggle bit0 once with data 0x1234, ch 2 -> m_valid_o high 3 edges later, m_data_o=0x1234, m_ch_o=2, occupancy 1, ack=1.
REQ-033 9 writes with m_ready_i=0 and DEPTH=8 -> full=1, occupancy 8, overflow=1, 9th word absent, ack flipped 9 times.
REQ-034 When full, hold m_ready_i=1 and write on the pop edge -> occupancy stays 8, overflow stays 0, FIFO order preserved.
REQ-035 4 queued words, flush high 4 cycles -> empty=1, m_valid_o=0, overflow=0; a write during flush is dropped but acked.
REQ-036 With LA_BRIDGE_PARITY_EN, data 0x0001, ch 0, la_par_i=0 -> no push, status[4]=1, ack flips; without the macro the word is pushed and status[4]=0.
REQ-037 Assert wb_rst_n_i low mid-stream with 3 words queued -> outputs match REQ-026 immediately, without waiting for a clock edge.
